// File: rtl/parking_ctrl_param.sv
// Parking lot occupancy controller with a reserved (uni) zone and a public (free) zone.
// A built-in hour counter shrinks the reserved zone on a configurable release schedule.
module parking_ctrl_param #(
    parameter int W                  = 10,
    parameter int TOTAL_CAP          = 700,
    parameter int UNI_CAP_MAX        = 500,
    parameter int UNI_CAP_MIN        = 200,
    parameter int RELEASE_START_HOUR = 13,
    parameter int RELEASE_STEP       = 50,
    parameter int START_HOUR         = 8,
    parameter int CYCLES_PER_HOUR    = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         car_entered,
    input  logic         is_uni_car_entered,
    input  logic         car_exited,
    input  logic         is_uni_car_exited,
    output logic [W-1:0] uni_parked_car,
    output logic [W-1:0] parked_car,
    output logic [W-1:0] uni_vacated_space,
    output logic [W-1:0] vacated_space,
    output logic         uni_is_vacated_space,
    output logic         is_vacated_space,
    output logic         illegal_enter,
    output logic         illegal_exit,
    output logic [4:0]   hour
);

    localparam int CW = (CYCLES_PER_HOUR > 1) ? $clog2(CYCLES_PER_HOUR) : 1;

    typedef struct packed {
        logic enter;
        logic enter_uni;
        logic leave;
        logic leave_uni;
    } req_t;

    req_t          req;
    logic [CW-1:0] cyc;
    logic [4:0]    hour_q;
    logic [W-1:0]  uni_cnt, free_cnt;
    logic          ie_q, ix_q;

    logic [31:0]   release_amt;
    logic [W-1:0]  uni_cap, free_cap, uni_excess, uni_vac, free_vac;
    logic [W:0]    free_used;
    logic          enter_ok, exit_ok;
    logic          uni_inc, uni_dec, free_inc, free_dec;

    assign req = '{enter: car_entered, enter_uni: is_uni_car_entered,
                   leave: car_exited,  leave_uni: is_uni_car_exited};

    // Release is computed in 32 bits and clamped before subtracting, so no underflow.
    always_comb begin
        release_amt = '0;
        uni_cap     = W'(UNI_CAP_MAX);
        if (32'(hour_q) > 32'(RELEASE_START_HOUR)) begin
            release_amt = 32'(RELEASE_STEP) * (32'(hour_q) - 32'(RELEASE_START_HOUR));
            if (release_amt >= 32'(UNI_CAP_MAX - UNI_CAP_MIN))
                uni_cap = W'(UNI_CAP_MIN);
            else
                uni_cap = W'(32'(UNI_CAP_MAX) - release_amt);
        end
    end

    // Uni cars stranded above a shrunken zone eat into the free zone.
    always_comb begin
        free_cap   = W'(TOTAL_CAP) - uni_cap;
        uni_excess = (uni_cnt > uni_cap) ? uni_cnt - uni_cap : '0;
        uni_vac    = (uni_cap > uni_cnt) ? uni_cap - uni_cnt : '0;
        free_used  = {1'b0, free_cnt} + {1'b0, uni_excess};
        free_vac   = ({1'b0, free_cap} > free_used) ? W'({1'b0, free_cap} - free_used) : '0;
    end

    // Entry and exit are judged independently on pre-edge state.
    always_comb begin
        enter_ok = req.enter & (req.enter_uni ? (uni_vac != '0) : (free_vac != '0));
        exit_ok  = req.leave & (req.leave_uni ? (uni_cnt != '0) : (free_cnt != '0));
        uni_inc  = enter_ok &  req.enter_uni;
        free_inc = enter_ok & ~req.enter_uni;
        uni_dec  = exit_ok  &  req.leave_uni;
        free_dec = exit_ok  & ~req.leave_uni;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc      <= '0;
            hour_q   <= 5'(START_HOUR);
            uni_cnt  <= '0;
            free_cnt <= '0;
            ie_q     <= 1'b0;
            ix_q     <= 1'b0;
        end else begin
            if (cyc == CW'(CYCLES_PER_HOUR - 1)) begin
                cyc    <= '0;
                hour_q <= (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else begin
                cyc <= cyc + CW'(1);
            end
            uni_cnt  <= uni_cnt  + W'(uni_inc)  - W'(uni_dec);
            free_cnt <= free_cnt + W'(free_inc) - W'(free_dec);
            ie_q     <= req.enter & ~enter_ok;
            ix_q     <= req.leave & ~exit_ok;
        end
    end

    assign uni_parked_car       = uni_cnt;
    assign parked_car           = free_cnt;
    assign uni_vacated_space    = uni_vac;
    assign vacated_space        = free_vac;
    assign uni_is_vacated_space = (uni_vac != '0);
    assign is_vacated_space     = (free_vac != '0);
    assign illegal_enter        = ie_q;
    assign illegal_exit         = ix_q;
    assign hour                 = hour_q;

endmodule

// File: tb/tb_parking_ctrl_param.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_parking_ctrl_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       car_entered = 1'b0, is_uni_car_entered = 1'b0;
    logic       car_exited = 1'b0, is_uni_car_exited = 1'b0;
    logic [9:0] uni_parked_car, parked_car, uni_vacated_space, vacated_space;
    logic       uni_is_vacated_space, is_vacated_space, illegal_enter, illegal_exit;
    logic [4:0] hour;

    parking_ctrl_param dut (
        .clk(clk), .reset(reset),
        .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
        .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
        .uni_parked_car(uni_parked_car), .parked_car(parked_car),
        .uni_vacated_space(uni_vacated_space), .vacated_space(vacated_space),
        .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
        .illegal_enter(illegal_enter), .illegal_exit(illegal_exit), .hour(hour)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   id;
        int   u, p, uv, v;
        logic ie, ix;
        int   hr;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Wall-clock reference: 256 edges per hour, starting at hour 8.
    int mc, mh;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mc = 0; mh = 8;
        end else if (mc == 255) begin
            mc = 0; mh = (mh == 23) ? 0 : mh + 1;
        end else begin
            mc = mc + 1;
        end
    end

    task automatic cmp(input int id, input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL chk%0d %s: got %0d expected %0d", id, nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.id, "uni_parked_car",    int'(uni_parked_car),    e.u);
            cmp(e.id, "parked_car",        int'(parked_car),        e.p);
            cmp(e.id, "uni_vacated_space", int'(uni_vacated_space), e.uv);
            cmp(e.id, "vacated_space",     int'(vacated_space),     e.v);
            cmp(e.id, "uni_is_vacated",    int'(uni_is_vacated_space), int'(e.uv != 0));
            cmp(e.id, "is_vacated",        int'(is_vacated_space),     int'(e.v != 0));
            cmp(e.id, "illegal_enter",     int'(illegal_enter), int'(e.ie));
            cmp(e.id, "illegal_exit",      int'(illegal_exit),  int'(e.ix));
            cmp(e.id, "hour",              int'(hour),          e.hr);
        end
    end

    int nid = 0;
    task automatic expect_st(input int u, p, uv, v, input logic ie, ix);
        exp_t e;
        e.id = nid; e.u = u; e.p = p; e.uv = uv; e.v = v;
        e.ie = ie; e.ix = ix; e.hr = mh;
        nid++;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int h, input int maxc);
        for (int i = 0; i < maxc && mh != h; i++) tick();
        if (mh != h) begin
            errors++;
            $display("FAIL run_until: hour %0d expected %0d within %0d cycles", mh, h, maxc);
        end
    endtask

    initial begin
        #20 reset = 1'b0;
        // 1: post-reset state
        tick();
        expect_st(0, 0, 500, 200, 0, 0);

        // 2: hold uni entry 512 cycles, saturates at 500
        car_entered = 1; is_uni_car_entered = 1;
        for (int i = 0; i < 500; i++) tick();
        expect_st(500, 0, 0, 200, 0, 0);
        tick();
        expect_st(500, 0, 0, 200, 1, 0);
        for (int i = 0; i < 11; i++) tick();
        expect_st(500, 0, 0, 200, 1, 0);
        car_entered = 0; is_uni_car_entered = 0;

        // 3: zone shrink; hour 14 cap 450, hour 16 cap 350
        run_until(14, 2000);
        expect_st(500, 0, 0, 200, 0, 0);
        run_until(16, 600);
        expect_st(500, 0, 0, 200, 0, 0);
        car_exited = 1; is_uni_car_exited = 1;
        tick();
        expect_st(499, 0, 0, 201, 0, 0);

        // 4: illegal free exit, then two free entries
        is_uni_car_exited = 0;
        tick();
        expect_st(499, 0, 0, 201, 0, 1);
        car_exited = 0; car_entered = 1;
        tick();
        expect_st(499, 1, 0, 200, 0, 0);
        tick();
        expect_st(499, 2, 0, 199, 0, 0);

        // 5: free entry + uni exit together; then fill and same-cycle free exit+entry
        car_exited = 1; is_uni_car_exited = 1;
        tick();
        expect_st(498, 3, 0, 199, 0, 0);
        car_exited = 0; is_uni_car_exited = 0;
        for (int i = 0; i < 199; i++) tick();
        expect_st(498, 202, 0, 0, 0, 0);
        car_exited = 1;
        tick();
        expect_st(498, 201, 0, 1, 1, 0);
        car_exited = 0; car_entered = 0;

        // 6: hour 23 (cap floor 200), wrap to 0 (cap 500, free vacancy saturates)
        run_until(23, 2500);
        expect_st(498, 201, 0, 1, 0, 0);
        run_until(0, 300);
        expect_st(498, 201, 2, 0, 0, 0);
        car_entered = 1;
        tick();
        expect_st(498, 201, 2, 0, 1, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 expect_st(0, 0, 500, 200, 0, 0);
        car_entered = 0;
        @(posedge clk);
        #4 reset = 1'b0;
        tick();
        expect_st(0, 0, 500, 200, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
